soc_system_pio_edge_in: RTL and testbench
=========================================

# soc_system_pio_edge_in

Parametrised Avalon-MM input PIO for the `soc_system` fabric. It samples an external `in_port` bus through a configurable synchroniser and latches edges into a sticky capture register. Per-bit masked interrupts are raised to the HPS/Nios interrupt controller. It is the next generation of the fixed 32-bit read-only input port: it keeps the same register-0 read behaviour and adds synchronisation, edge capture and an interrupt line.

## Interface
Parameters:
- `WIDTH`, 32, number of input bits; legal range 1..32; readdata bits above `WIDTH` read 0.
- `SYNC_STAGES`, 2, number of synchroniser flops on `in_port`; legal range 2..4.
- `EDGE_TYPE`, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
- `IRQ_MODE`, 1, interrupt source: 0 = level (synchronised data & mask), 1 = edge (capture & mask).
- `RESET_MASK`, 0, reset value of the irqmask register, `WIDTH` bits.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk` (release is synchronised upstream).
- `address`  in  2  register word address.
- `chipselect`  in  1  slave select, active high.
- `write_n`  in  1  write strobe, active low; a write occurs when `chipselect` = 1 and `write_n` = 0.
- `writedata`  in  32  write data.
- `in_port`  in  `WIDTH`  asynchronous external inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  interrupt request, active high, level.

## Operation
- Synchroniser: `in_port` passes through `SYNC_STAGES` flops to produce `sync_q`. A further flop holds `sync_d`, the previous value of `sync_q`.
- Edge detect, per bit:
  - rising = `sync_q & ~sync_d`
  - falling = `~sync_q & sync_d`
  - any = XOR of the two
- Register map:
  - 0 data: read returns `sync_q`. Writes are ignored.
  - 1 reserved: reads 0. Writes are ignored.
  - 2 irqmask: read/write, `WIDTH` bits. `writedata` bits above `WIDTH` are dropped.
  - 3 edgecapture: read returns the sticky capture bits. A write clears bits as described under Configuration.
- Capture: each cycle, edgecapture[i] is set to 1 when the selected edge is detected on bit i, and otherwise holds its value unless cleared.
- Simultaneous edge detect and clear on the same bit in the same cycle: set wins, and the bit stays 1.
- `irq`:
  - `IRQ_MODE`=1: `irq` = OR-reduce(edgecapture & irqmask).
  - `IRQ_MODE`=0: `irq` = OR-reduce(`sync_q` & irqmask).
  - `irq` is combinational from registers only, so it is glitch-free with respect to the bus.
- Reading has no side effects. `readdata` is updated every cycle from the address-selected mux, whether or not `chipselect` is high.
- Unused configurations are legal. For example, with `IRQ_MODE`=0 the edgecapture register still functions.

## Timing
- Reset values:
  - `readdata` = 0.
  - `irq` = 0 when `RESET_MASK` is 0. Otherwise `irq` follows the reset register values (capture bits are 0 at reset).
  - All synchroniser flops and `sync_d` = 0.
  - edgecapture = 0.
  - irqmask = `RESET_MASK`.
- Input latency: a change on `in_port` set up before clock edge N appears on `sync_q` after edge N+`SYNC_STAGES`-1.
- Capture latency: the capture bit sets at edge N+`SYNC_STAGES`. In edge mode, `irq` rises in the same cycle.
- Read latency: one cycle. `readdata` at edge M+1 reflects `address` and register state sampled at edge M.
- Write latency: a write sampled at edge M takes effect after edge M. The effect on `irq` is visible in the cycle after edge M.
- Edges present on `sync_q`/`sync_d` at reset release are not captured, because both registers reset to 0.
- A reset during operation clears all state immediately and asynchronously. Pending interrupts are lost.

## Configuration
- `SOC_PIO_BIT_CLEAR_EN`:
  - Defined: a write to edgecapture is write-1-to-clear. Bit i is cleared only where `writedata`[i] = 1; bits written 0 are unchanged.
  - Not defined: any write to address 3 clears all edgecapture bits, regardless of `writedata`.

## Test plan
- Reset and data read: `WIDTH`=8, `in_port`=0xA5 held, read address 0 → `readdata`=0x000000A5. `readdata`=0 while `reset_n`=0.
- Rising capture and irq: `EDGE_TYPE`=0, mask=0x01, `in_port` bit0 goes 0→1 before edge N → edgecapture=0x01 and `irq`=1 after edge N+2 (`SYNC_STAGES`=2).
- Falling/any edges: `EDGE_TYPE`=1, bit3 toggles 1→0→1 → capture=0x08 set once. With `EDGE_TYPE`=2, both transitions set the bit; the bit is cleared between them.
- Clear semantics:
  - Capture=0x0F, write 0x05 to address 3. With `SOC_PIO_BIT_CLEAR_EN` → 0x0A; without → 0x00.
  - With `SOC_PIO_BIT_CLEAR_EN`, a write of 0 leaves 0x0F unchanged.
- Set/clear collision: edge on bit1 detected in the same cycle as a clear write of 0x02 → bit1 reads 1 afterwards and `irq` stays high when masked.
- Level mode with mid-operation reset: `IRQ_MODE`=0, mask=0x80, `in_port`=0x80 → `irq`=1. Assert `reset_n`=0 → `irq`, `readdata` and edgecapture go to 0 immediately, and irqmask returns to `RESET_MASK`.

Source files
------------

// File: rtl/soc_system_pio_edge_in.sv
// Avalon-MM input PIO: synchronised in_port, sticky edge capture, masked irq.
// Define SOC_PIO_BIT_CLEAR_EN for write-1-to-clear edgecapture; otherwise any write to it clears all bits.
module soc_system_pio_edge_in #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_MODE    = 1,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_dly_q;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], in_port};
  assign sync_q       = sync_chain_q[SYNC_STAGES-1];
  assign unused_wdata = ^writedata;

  assign rise = sync_q & ~sync_dly_q;
  assign fall = ~sync_q & sync_dly_q;

  always_comb begin
    edge_det = rise;
    if (EDGE_TYPE == 1)
      edge_det = fall;
    else if (EDGE_TYPE == 2)
      edge_det = rise | fall;
  end

  always_comb begin
`ifdef SOC_PIO_BIT_CLEAR_EN
    clr_bits = writedata[WIDTH-1:0];
`else
    clr_bits = '1;
`endif
    if (!(wr_en && (address == ADDR_CAPTURE)))
      clr_bits = '0;
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  assign capture_d = (capture_q & ~clr_bits) | edge_det;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == ADDR_IRQMASK))
      mask_d = writedata[WIDTH-1:0];
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(sync_q);
      ADDR_IRQMASK: readdata_d = 32'(mask_q);
      ADDR_CAPTURE: readdata_d = 32'(capture_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain_q <= '0;
      sync_dly_q   <= '0;
      mask_q       <= RESET_MASK;
      capture_q    <= '0;
      readdata_q   <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      sync_dly_q   <= sync_q;
      mask_q       <= mask_d;
      capture_q    <= capture_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  generate
    if (IRQ_MODE == 1) begin : g_irq_edge
      assign irq = |(capture_q & mask_q);
    end else begin : g_irq_level
      assign irq = |(sync_q & mask_q);
    end
  endgenerate

endmodule

// File: tb/tb_soc_system_pio_edge_in.sv
// Directed bench for soc_system_pio_edge_in: four instances cover rising, falling, any-edge and level-irq builds.
module tb_soc_system_pio_edge_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1, in2, in3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_system_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1), .RESET_MASK(8'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  soc_system_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(1), .RESET_MASK(8'h00)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
  soc_system_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1), .RESET_MASK(8'h08)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));
  soc_system_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(0), .IRQ_MODE(0), .RESET_MASK(8'h00)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    tick(2);
    n_checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0 || rd2 !== 32'h0 || rd3 !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h %h %h %h want 0", rd0, rd1, rd2, rd3);
    end
    n_checks++;
    if ({irq0, irq1, irq2, irq3} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_irq: got %b want 0000", {irq0, irq1, irq2, irq3});
    end
    reset_n = 1'b1;
    address = 2'd2;
    tick(1);
    n_checks++;
    if (rd2 !== 32'h08 || rd0 !== 32'h00) begin
      n_fail++; $display("FAIL reset_mask: got %h/%h want 08/00", rd2, rd0);
    end
  endtask

  task automatic test_data_read;
    in0 = 8'hA5;
    tick(3);
    address = 2'd0;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL data_read: got %h want 000000a5", rd0);
    end
    address = 2'd1;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h0) begin
      n_fail++; $display("FAIL reserved_read: got %h want 0", rd0);
    end
  endtask

  task automatic test_rising;
    in0 = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FF01);
    address = 2'd2;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h01) begin
      n_fail++; $display("FAIL mask_width: got %h want 00000001", rd0);
    end
    n_checks++;
    if (irq0 !== 1'b0) begin
      n_fail++; $display("FAIL rise_irq_idle: got %b want 0", irq0);
    end
    in0 = 8'h01;
    tick(2);
    n_checks++;
    if (irq0 !== 1'b0) begin
      n_fail++; $display("FAIL rise_irq_early: got %b want 0", irq0);
    end
    tick(1);
    n_checks++;
    if (irq0 !== 1'b1) begin
      n_fail++; $display("FAIL rise_irq_n2: got %b want 1", irq0);
    end
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h01) begin
      n_fail++; $display("FAIL rise_capture: got %h want 00000001", rd0);
    end
  endtask

  task automatic test_falling;
    in1 = 8'h08;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1 = 8'h00;
    tick(4);
    in1 = 8'h08;
    tick(4);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd1 !== 32'h08) begin
      n_fail++; $display("FAIL fall_capture: got %h want 00000008", rd1);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1 = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in1 = 8'h08;
    tick(4);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd1 !== 32'h00) begin
      n_fail++; $display("FAIL fall_ignores_rise: got %h want 0", rd1);
    end
  endtask

  task automatic test_any;
    bus_write(2'd3, 32'hFFFF_FFFF);
    in2 = 8'h08;
    tick(4);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd2 !== 32'h08) begin
      n_fail++; $display("FAIL any_rise: got %h want 00000008", rd2);
    end
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd2 !== 32'h00) begin
      n_fail++; $display("FAIL any_cleared: got %h want 0", rd2);
    end
    in2 = 8'h00;
    tick(4);
    n_checks++;
    if (rd2 !== 32'h08) begin
      n_fail++; $display("FAIL any_fall: got %h want 00000008", rd2);
    end
  endtask

  task automatic test_clear;
    in0 = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in0 = 8'h0F;
    tick(4);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h0F) begin
      n_fail++; $display("FAIL clear_setup: got %h want 0000000f", rd0);
    end
    bus_write(2'd3, 32'h0000_0005);
    tick(1);
    n_checks++;
`ifdef SOC_PIO_BIT_CLEAR_EN
    if (rd0 !== 32'h0A) begin
      n_fail++; $display("FAIL clear_w1c: got %h want 0000000a", rd0);
    end
`else
    if (rd0 !== 32'h00) begin
      n_fail++; $display("FAIL clear_all: got %h want 0", rd0);
    end
`endif
    in0 = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in0 = 8'h0F;
    tick(4);
    bus_write(2'd3, 32'h0000_0000);
    tick(1);
    n_checks++;
`ifdef SOC_PIO_BIT_CLEAR_EN
    if (rd0 !== 32'h0F) begin
      n_fail++; $display("FAIL clear_zero_w1c: got %h want 0000000f", rd0);
    end
`else
    if (rd0 !== 32'h00) begin
      n_fail++; $display("FAIL clear_zero_all: got %h want 0", rd0);
    end
`endif
  endtask

  task automatic test_collision;
    in0 = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h0000_0002);
    n_checks++;
    if (irq0 !== 1'b0) begin
      n_fail++; $display("FAIL collide_idle_irq: got %b want 0", irq0);
    end
    in0 = 8'h02;
    tick(2);
    bus_write(2'd3, 32'h0000_0002);
    n_checks++;
    if (irq0 !== 1'b1) begin
      n_fail++; $display("FAIL collide_irq: got %b want 1", irq0);
    end
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd0 !== 32'h02) begin
      n_fail++; $display("FAIL collide_capture: got %h want 00000002", rd0);
    end
  endtask

  task automatic test_level_reset;
    bus_write(2'd2, 32'h0000_0080);
    in3 = 8'h80;
    tick(2);
    n_checks++;
    if (irq3 !== 1'b0) begin
      n_fail++; $display("FAIL level_irq_early: got %b want 0", irq3);
    end
    tick(1);
    n_checks++;
    if (irq3 !== 1'b1) begin
      n_fail++; $display("FAIL level_irq: got %b want 1", irq3);
    end
    tick(2);
    address = 2'd3;
    tick(1);
    n_checks++;
    if (rd3 !== 32'h80) begin
      n_fail++; $display("FAIL level_capture: got %h want 00000080", rd3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq3 !== 1'b0 || rd3 !== 32'h0 || rd0 !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got irq=%b rd3=%h rd0=%h want 0", irq3, rd3, rd0);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    n_checks++;
    if (rd3 !== 32'h0) begin
      n_fail++; $display("FAIL reset_capture: got %h want 0", rd3);
    end
    address = 2'd2;
    tick(1);
    n_checks++;
    if (rd3 !== 32'h0 || rd2 !== 32'h08) begin
      n_fail++; $display("FAIL reset_mask_restore: got %h/%h want 0/08", rd3, rd2);
    end
    tick(4);
    n_checks++;
    if (irq3 !== 1'b0) begin
      n_fail++; $display("FAIL level_irq_after_reset: got %b want 0", irq3);
    end
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_rising();
    test_falling();
    test_any();
    test_clear();
    test_collision();
    test_level_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
